fifo_stream_reader: RTL and testbench
=====================================

// Module: fifo_stream_reader
// PURPOSE
//  Read-side engine for the synchronous FIFO: drives rd_en against empty and the FIFO's
//  one-cycle registered read data. Re-times data into a valid/ready stream for the consumer.
//  A 2-entry output buffer gives full throughput under backpressure with no loss or duplication.
//  Also keeps a transfer counter and flags a sticky error on FIFO underflow.
// PARAMETERS
//  DATA_WIDTH  16  width of FIFO read data and stream data
//  CNT_WIDTH   16  width of xfer_count (wraps modulo 2^CNT_WIDTH)
// PORTS
//  clk             in   1           single clock, all logic on posedge
//  rst             in   1           synchronous, active-high reset
//  en              in   1           1 = fetch from FIFO; 0 = stop fetching, finish in-flight read
//  fifo_rd_en      out  1           FIFO read enable
//  fifo_dout       in   DATA_WIDTH  FIFO read data, valid the cycle after fifo_rd_en
//  fifo_empty      in   1           FIFO empty flag
//  fifo_underflow  in   1           FIFO underflow flag (read issued while empty)
//  m_valid         out  1           stream data valid
//  m_data          out  DATA_WIDTH  stream data
//  m_ready         in   1           consumer ready; transfer when m_valid && m_ready
//  busy            out  1           state != IDLE or output buffer non-empty
//  xfer_count      out  CNT_WIDTH   completed stream transfers
//  err_underflow   out  1           sticky underflow error
// BEHAVIOUR
//  Reset (rst=1 at posedge), all values:
//   - state=IDLE; buffer empty; inflight=0.
//   - fifo_rd_en=0 (also forced 0 combinationally while rst=1).
//   - m_valid=0, m_data=0, busy=0, xfer_count=0, err_underflow=0.
//   - Reset mid-operation discards buffered and in-flight words.
//  Buffer and credit:
//   - occ: output-buffer occupancy, 0..2. inflight: read issued last cycle, 0/1.
//   - pop = m_valid && m_ready.
//   - fifo_rd_en = (state==ACTIVE) && !fifo_empty && (occ + inflight - pop < 2).
//   - fifo_rd_en is combinational; the m_ready -> fifo_rd_en path is intended.
//   - A word lands (pushed into buffer) the cycle after fifo_rd_en, unless fifo_underflow=1 that cycle.
//   - Order preserved. m_data is a register: head entry, skid entry behind it.
//   - Latency: fifo_rd_en in cycle N -> m_valid high in cycle N+2.
//   - Steady state with m_ready=1 and FIFO non-empty: one word per cycle.
//   - Once high, m_valid stays high and m_data stays stable until pop.
//   - Simultaneous push and pop: occ unchanged, ordering kept.
//   - Buffer never overflows: credit rule guarantees occ<=2.
//  FSM:
//   - IDLE -> ACTIVE when en=1.
//   - ACTIVE -> STOP when en=0 and (inflight or fifo_rd_en this cycle); else ACTIVE -> IDLE when en=0.
//   - STOP -> IDLE once the in-flight word has landed. No reads issued in STOP or IDLE.
//   - en=1 during STOP is ignored until IDLE is reached.
//   - Buffered words keep draining to the consumer in every state.
//  Empty FIFO: en=1 with fifo_empty=1 -> no read; waits in ACTIVE.
//  Underflow: fifo_underflow=1 in any cycle -> err_underflow=1 next cycle.
//   - err_underflow holds until rst.
//   - The word landing in that cycle is dropped and inflight is cleared.
//  xfer_count: +1 per pop; wraps 2^CNT_WIDTH-1 -> 0.
// TESTING
//  1. rst=1 for 2 cycles, en=1, fifo_empty=0
//     -> fifo_rd_en=0, m_valid=0, xfer_count=0, err_underflow=0, busy=0.
//  2. FIFO holds 0x0001..0x0008, m_ready=1, en=1
//     -> 8 consecutive m_valid beats 0x0001..0x0008; first beat 2 cycles after first fifo_rd_en; xfer_count=8.
//  3. Same data, m_ready=0
//     -> exactly 2 reads issued, then fifo_rd_en=0; m_data holds 0x0001.
//     -> after m_ready=1: 0x0001..0x0008 in order, no gap after refill, no duplicates.
//  4. en dropped in the cycle fifo_rd_en=1 for 0x0003
//     -> STOP, 0x0003 delivered, no further fifo_rd_en, busy=0 after last pop, state IDLE.
//  5. fifo_underflow=1 in a landing cycle
//     -> err_underflow=1 next cycle and sticky; that word never appears on m_data.
//     -> rst clears err_underflow.
//  6. CNT_WIDTH=4, 17 transfers -> xfer_count=1.

Source files
------------

// File: rtl/fifo_stream_reader.sv
// Read-side engine for a synchronous FIFO: issues reads and re-times the data into a valid/ready stream.
// Latency: fifo_rd_en in cycle N -> m_valid in cycle N+2 (one FIFO read cycle, one buffer register).
// Backpressure: a 2-entry output buffer plus read credit keeps full throughput under m_ready stalls, with no loss or duplication.
//
// Ports:
//   clk, rst                        single clock, synchronous active-high reset
//   en                              fetch enable (dropping it finishes any in-flight read)
//   fifo_rd_en / fifo_dout          FIFO read request and read data (data is valid the cycle after the request)
//   fifo_empty / fifo_underflow     FIFO status flags
//   m_valid / m_data / m_ready      output stream
//   busy, xfer_count, err_underflow status outputs
module fifo_stream_reader #(
    parameter int DATA_WIDTH = 16,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    output logic                  fifo_rd_en,
    input  logic [DATA_WIDTH-1:0] fifo_dout,
    input  logic                  fifo_empty,
    input  logic                  fifo_underflow,
    output logic                  m_valid,
    output logic [DATA_WIDTH-1:0] m_data,
    input  logic                  m_ready,
    output logic                  busy,
    output logic [CNT_WIDTH-1:0]  xfer_count,
    output logic                  err_underflow
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACTIVE = 2'd1,
        S_STOP   = 2'd2
    } state_t;

    state_t                state;
    state_t                state_nxt;

    logic [1:0]            occ;        // output buffer occupancy, 0..2
    logic                  inflight;   // read issued last cycle, its data lands this cycle
    logic [DATA_WIDTH-1:0] head;       // oldest buffered word, drives m_data
    logic [DATA_WIDTH-1:0] skid;       // second word, only used while head is stalled
    logic                  pop;
    logic                  push;
    logic [2:0]            credit_used;

    assign m_valid = (occ != 2'd0);
    assign m_data  = head;
    assign pop     = m_valid && m_ready;
    // A landing word is discarded when the FIFO reports underflow in that cycle.
    assign push    = inflight && !fifo_underflow;

    // Slots that will be occupied next cycle if no new read is issued.
    // pop implies occ >= 1, so this never goes negative.
    assign credit_used = {1'b0, occ} + {2'b00, inflight} - {2'b00, pop};

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (en) state_nxt = S_ACTIVE;
            end
            S_ACTIVE: begin
                if (!en) begin
                    // A read still outstanding after this cycle has to land before IDLE.
                    if (inflight || fifo_rd_en) state_nxt = S_STOP;
                    else                        state_nxt = S_IDLE;
                end
            end
            S_STOP: begin
                // No reads are issued in STOP, so the single outstanding read
                // lands during this cycle; en is ignored here.
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        fifo_rd_en = 1'b0;
        busy       = 1'b0;
        // Combinational m_ready -> fifo_rd_en path is deliberate: a pop this
        // cycle frees a slot for the read issued this cycle.
        if (!rst && (state == S_ACTIVE) && !fifo_empty && (credit_used < 3'd2)) begin
            fifo_rd_en = 1'b1;
        end
        if ((state != S_IDLE) || (occ != 2'd0)) begin
            busy = 1'b1;
        end
    end

    // ---------------- output buffer ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            occ      <= 2'd0;
            inflight <= 1'b0;
            head     <= '0;
            skid     <= '0;
        end else begin
            inflight <= fifo_rd_en;
            case ({push, pop})
                2'b10: begin
                    // Credit guarantees occ < 2 here.
                    if (occ == 2'd0) head <= fifo_dout;
                    else             skid <= fifo_dout;
                    occ <= occ + 2'd1;
                end
                2'b01: begin
                    if (occ == 2'd2) head <= skid;
                    occ <= occ - 2'd1;
                end
                2'b11: begin
                    // Occupancy unchanged; the new word goes to the tail.
                    if (occ == 2'd2) begin
                        head <= skid;
                        skid <= fifo_dout;
                    end else begin
                        head <= fifo_dout;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // ---------------- status ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            xfer_count    <= '0;
            err_underflow <= 1'b0;
        end else begin
            if (pop)            xfer_count    <= xfer_count + 1'b1;
            if (fifo_underflow) err_underflow <= 1'b1;
        end
    end

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Testbench for fifo_stream_reader: FIFO and consumer driven per cycle, outputs checked against a queue-based model.
// Latency: checks land 1 time unit after each negedge, before the next posedge.
// Backpressure: m_ready is driven directly (held low or randomized) to exercise the output buffer.
module tb_fifo_stream_reader;

    localparam int DW = 16;
    localparam int CW = 4;

    logic          clk;
    logic          rst;
    logic          en;
    logic          fifo_rd_en;
    logic [DW-1:0] fifo_dout;
    logic          fifo_empty;
    logic          fifo_underflow;
    logic          m_valid;
    logic [DW-1:0] m_data;
    logic          m_ready;
    logic          busy;
    logic [CW-1:0] xfer_count;
    logic          err_underflow;

    fifo_stream_reader #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
        .clk            (clk),
        .rst            (rst),
        .en             (en),
        .fifo_rd_en     (fifo_rd_en),
        .fifo_dout      (fifo_dout),
        .fifo_empty     (fifo_empty),
        .fifo_underflow (fifo_underflow),
        .m_valid        (m_valid),
        .m_data         (m_data),
        .m_ready        (m_ready),
        .busy           (busy),
        .xfer_count     (xfer_count),
        .err_underflow  (err_underflow)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Planned inputs for the next cycle.
    bit rst_v, en_v, rdy_v, uf_v;

    // FIFO model: stored words plus its registered read data.
    logic [DW-1:0] fq[$];
    logic [DW-1:0] dout_m;

    // Reader model: mode 0=idle 1=fetching 2=draining last read.
    int            mode_m;
    logic [DW-1:0] buf_m[$];
    bit            inflight_m;
    int            count_m;
    bit            err_m;

    function automatic bit pred_rd_en();
        int p;
        p = (buf_m.size() > 0 && rdy_v) ? 1 : 0;
        return !rst_v && mode_m == 1 && fq.size() > 0 &&
               (buf_m.size() + int'(inflight_m) - p) < 2;
    endfunction

    task automatic step();
        bit            rde;
        bit            pop;
        bit            uf;
        logic [DW-1:0] landed;
        @(negedge clk);
        rde            = pred_rd_en();
        // Underflow is only injected in a landing cycle with no new read.
        uf             = uf_v && inflight_m && !rde;
        rst            = rst_v;
        en             = en_v;
        m_ready        = rdy_v;
        fifo_empty     = (fq.size() == 0);
        fifo_dout      = dout_m;
        fifo_underflow = uf;
        landed         = dout_m;
        #1;
        pop = (buf_m.size() > 0) && rdy_v;
        chk("rd_en", 32'(fifo_rd_en), 32'(rde));
        chk("valid", 32'(m_valid), 32'(buf_m.size() > 0));
        if (buf_m.size() > 0) chk("data", 32'(m_data), 32'(buf_m[0]));
        chk("busy", 32'(busy), 32'(mode_m != 0 || buf_m.size() > 0));
        chk("count", 32'(xfer_count), 32'(count_m));
        chk("err", 32'(err_underflow), 32'(err_m));
        if (rst_v) begin
            mode_m     = 0;
            buf_m      = {};
            inflight_m = 0;
            count_m    = 0;
            err_m      = 0;
        end else begin
            if (pop) begin
                void'(buf_m.pop_front());
                count_m = (count_m + 1) % (1 << CW);
            end
            if (inflight_m && !uf) buf_m.push_back(landed);
            if (uf) err_m = 1;
            case (mode_m)
                0: if (en_v) mode_m = 1;
                1: if (!en_v) mode_m = (inflight_m || rde) ? 2 : 0;
                default: mode_m = 0;
            endcase
            inflight_m = rde;
        end
        if (rde) dout_m = fq.pop_front();
    endtask

    task automatic do_reset(input int n);
        rst_v = 1; uf_v = 0;
        repeat (n) step();
        rst_v = 0;
    endtask

    task automatic fill(input int n);
        fq = {};
        for (int i = 1; i <= n; i++) fq.push_back(DW'(i));
    endtask

    initial begin
        rst = 1; en = 0; m_ready = 0; fifo_dout = '0;
        fifo_empty = 1; fifo_underflow = 0;
        dout_m = '0; mode_m = 0; inflight_m = 0; count_m = 0; err_m = 0;
        rst_v = 1; en_v = 1; rdy_v = 0; uf_v = 0;

        // Reset with en=1 and a non-empty FIFO: no reads, all outputs idle.
        fill(8);
        do_reset(2);
        chk("rst_rd_en", 32'(fifo_rd_en), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);

        // Streaming 1..8 with the consumer always ready.
        en_v = 1; rdy_v = 1;
        repeat (14) step();
        chk("stream_count", 32'(xfer_count), 32'd8);

        // Backpressure: consumer stalled, then released.
        fill(8);
        do_reset(1);
        en_v = 1; rdy_v = 0;
        repeat (8) step();
        chk("stall_fifo_left", 32'(fq.size()), 32'd6);
        chk("stall_head", 32'(m_data), 32'h0001);
        rdy_v = 1;
        repeat (12) step();
        chk("stall_count", 32'(xfer_count), 32'd8);

        // en dropped in the cycle that reads word 3.
        fill(8);
        do_reset(1);
        en_v = 1; rdy_v = 1;
        for (int i = 0; i < 20; i++) begin
            if (en_v && pred_rd_en() && fq[0] == DW'(3)) en_v = 0;
            step();
        end
        chk("stop_count", 32'(xfer_count), 32'd3);
        chk("stop_left", 32'(fq.size()), 32'd5);
        chk("stop_busy", 32'(busy), 32'd0);

        // Underflow on a landing cycle: word dropped, error sticky until reset.
        fill(8);
        do_reset(1);
        en_v = 1; rdy_v = 0;
        for (int i = 0; i < 10; i++) begin
            uf_v = (!err_m && i > 2);
            step();
        end
        uf_v = 0;
        rdy_v = 1;
        repeat (12) step();
        chk("uf_sticky", 32'(err_underflow), 32'd1);
        do_reset(1);
        step();
        chk("uf_cleared", 32'(err_underflow), 32'd0);

        // 17 transfers wrap a 4-bit counter to 1.
        fill(17);
        do_reset(1);
        en_v = 1; rdy_v = 1;
        repeat (24) step();
        chk("wrap17", 32'(xfer_count), 32'd1);

        // Randomized traffic.
        fq = {};
        do_reset(1);
        for (int i = 0; i < 1500; i++) begin
            if (fq.size() < 12 && $urandom_range(0, 2) != 0) fq.push_back(DW'($urandom));
            en_v  = ($urandom_range(0, 9) < 8);
            rdy_v = ($urandom_range(0, 3) != 0);
            uf_v  = ($urandom_range(0, 99) == 0);
            rst_v = ($urandom_range(0, 299) == 0);
            step();
        end
        rst_v = 0; uf_v = 0; en_v = 0; rdy_v = 1;
        repeat (6) step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
